// File: rtl/l15_ch_arb_pkg.sv
// Shared types and constants for the L1.5 channel arbiter: request FSM
// state encoding, invalidation return type and request/response field widths.
package l15_ch_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } req_state_e;

    localparam logic [3:0]  RTYPE_INV = 4'b0011;

    localparam int unsigned RQTYPE_W  = 5;
    localparam int unsigned SIZE_W    = 3;
    localparam int unsigned ADDR_W    = 40;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned RTYPE_W   = 4;

endpackage

// File: rtl/l15_ch_arb_ord_fifo.sv
// Issue-order FIFO: holds the channel index of each outstanding L1.5 request
// so in-order responses can be routed back to their originator.
module l15_ch_arb_ord_fifo #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [IDX_W-1:0]           push_idx,
    input  logic                       pop,
    output logic [IDX_W-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/l15_ch_arb.sv
// Round-robin arbiter sharing one L1.5 request/response port among NUM_CH
// channels. Define L15_CH_ARB_RESP_BUF_EN to register the response path.
module l15_ch_arb
    import l15_ch_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ORD_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_req_val,
    input  logic [NUM_CH*RQTYPE_W-1:0]   ch_req_rqtype,
    input  logic [NUM_CH*SIZE_W-1:0]     ch_req_size,
    input  logic [NUM_CH*ADDR_W-1:0]     ch_req_address,
    input  logic [NUM_CH*DATA_W-1:0]     ch_req_data,
    output logic [NUM_CH-1:0]            ch_req_ack,
    output logic                         transducer_l15_val,
    output logic [RQTYPE_W-1:0]          transducer_l15_rqtype,
    output logic [SIZE_W-1:0]            transducer_l15_size,
    output logic [ADDR_W-1:0]            transducer_l15_address,
    output logic [DATA_W-1:0]            transducer_l15_data,
    output logic                         transducer_l15_threadid,
    input  logic                         l15_transducer_ack,
    input  logic                         l15_transducer_val,
    input  logic [RTYPE_W-1:0]           l15_transducer_returntype,
    input  logic [DATA_W-1:0]            l15_transducer_data_0,
    output logic                         transducer_l15_req_ack,
    output logic [NUM_CH-1:0]            ch_resp_val,
    output logic [RTYPE_W-1:0]           ch_resp_returntype,
    output logic [DATA_W-1:0]            ch_resp_data,
    input  logic [NUM_CH-1:0]            ch_resp_ack
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(ORD_DEPTH) + 1;

    localparam logic [0:0] S_IDLE  = ST_IDLE;
    localparam logic [0:0] S_ISSUE = ST_ISSUE;

    logic [0:0]          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant;
    logic [IDX_W-1:0]    nxt_idx;
    logic                nxt_found;
    logic                push;
    logic                pop;
    logic [IDX_W-1:0]    head;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    logic                r_val;
    logic [RTYPE_W-1:0]  r_type;
    logic [DATA_W-1:0]   r_data;
    logic                resp_inv;
    logic                done;
    logic [NUM_CH-1:0]   inv_acked;
    logic [NUM_CH-1:0]   inv_seen;

    assign fifo_full  = (fifo_count == CNT_W'(ORD_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // Search starts at the channel after the last one acked by L1.5.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand      = '0;
        nxt_found = 1'b0;
        nxt_idx   = rr_ptr;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = IDX_W'((32'(rr_ptr) + i) % NUM_CH);
            if (!nxt_found && ch_req_val[cand]) begin
                nxt_found = 1'b1;
                nxt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                  <= S_IDLE;
            rr_ptr                 <= IDX_W'(NUM_CH - 1);
            grant                  <= '0;
            transducer_l15_rqtype  <= '0;
            transducer_l15_size    <= '0;
            transducer_l15_address <= '0;
            transducer_l15_data    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (nxt_found && !fifo_full) begin
                        grant                  <= nxt_idx;
                        transducer_l15_rqtype  <= ch_req_rqtype[nxt_idx*RQTYPE_W +: RQTYPE_W];
                        transducer_l15_size    <= ch_req_size[nxt_idx*SIZE_W +: SIZE_W];
                        transducer_l15_address <= ch_req_address[nxt_idx*ADDR_W +: ADDR_W];
                        transducer_l15_data    <= ch_req_data[nxt_idx*DATA_W +: DATA_W];
                        state                  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (l15_transducer_ack) begin
                        rr_ptr <= grant;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign transducer_l15_val      = (state == S_ISSUE);
    assign transducer_l15_threadid = 1'b0;
    assign push = (state == S_ISSUE) && l15_transducer_ack && rst_n;

    always_comb begin
        ch_req_ack = '0;
        if (push) begin
            ch_req_ack[grant] = 1'b1;
        end
    end

`ifdef L15_CH_ARB_RESP_BUF_EN
    logic                capture;
    logic                buf_val;
    logic [RTYPE_W-1:0]  buf_type;
    logic [DATA_W-1:0]   buf_data;

    // Capture only into an empty buffer; done can only fire while it is full.
    assign capture = l15_transducer_val && !buf_val && rst_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_val  <= 1'b0;
            buf_type <= '0;
            buf_data <= '0;
        end else begin
            if (done) begin
                buf_val <= 1'b0;
            end
            if (capture) begin
                buf_val  <= 1'b1;
                buf_type <= l15_transducer_returntype;
                buf_data <= l15_transducer_data_0;
            end
        end
    end

    assign r_val  = buf_val;
    assign r_type = buf_type;
    assign r_data = buf_data;
    assign transducer_l15_req_ack = capture;
`else
    assign r_val  = l15_transducer_val;
    assign r_type = l15_transducer_returntype;
    assign r_data = l15_transducer_data_0;
    assign transducer_l15_req_ack = done;
`endif

    assign resp_inv = r_val && (r_type == RTYPE_INV);
    assign inv_seen = inv_acked | ch_resp_ack;

    // Channels that already acked an invalidation stop seeing it as valid.
    always_comb begin
        ch_resp_val = '0;
        done        = 1'b0;
        if (resp_inv) begin
            ch_resp_val = ~inv_acked;
            done        = &inv_seen;
        end else if (r_val && fifo_empty) begin
            done = 1'b1;
        end else if (r_val) begin
            ch_resp_val[head] = 1'b1;
            done              = ch_resp_ack[head];
        end
        done = done && rst_n;
    end

    assign pop = done && !resp_inv && !fifo_empty;
    assign ch_resp_returntype = r_type;
    assign ch_resp_data       = r_data;

    always_ff @(posedge clk) begin
        if (!rst_n || done) begin
            inv_acked <= '0;
        end else if (resp_inv) begin
            inv_acked <= inv_seen;
        end
    end

    l15_ch_arb_ord_fifo #(
        .DEPTH (ORD_DEPTH),
        .IDX_W (IDX_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_idx (grant),
        .pop      (pop),
        .head     (head),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_l15_ch_arb.sv
// Scoreboard bench for l15_ch_arb: directed stimulus pushes expected grants
// and responses into queues; a negedge monitor pops and compares them.
module tb_l15_ch_arb;
    import l15_ch_arb_pkg::*;

    localparam int NUM_CH    = 4;
    localparam int ORD_DEPTH = 4;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_CH-1:0]          ch_req_val;
    logic [NUM_CH*5-1:0]        ch_req_rqtype;
    logic [NUM_CH*3-1:0]        ch_req_size;
    logic [NUM_CH*40-1:0]       ch_req_address;
    logic [NUM_CH*64-1:0]       ch_req_data;
    logic [NUM_CH-1:0]          ch_req_ack;
    logic                       transducer_l15_val;
    logic [4:0]                 transducer_l15_rqtype;
    logic [2:0]                 transducer_l15_size;
    logic [39:0]                transducer_l15_address;
    logic [63:0]                transducer_l15_data;
    logic                       transducer_l15_threadid;
    logic                       l15_transducer_ack;
    logic                       l15_transducer_val;
    logic [3:0]                 l15_transducer_returntype;
    logic [63:0]                l15_transducer_data_0;
    logic                       transducer_l15_req_ack;
    logic [NUM_CH-1:0]          ch_resp_val;
    logic [3:0]                 ch_resp_returntype;
    logic [63:0]                ch_resp_data;
    logic [NUM_CH-1:0]          ch_resp_ack;

    l15_ch_arb #(.NUM_CH(NUM_CH), .ORD_DEPTH(ORD_DEPTH)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .ch_req_val                (ch_req_val),
        .ch_req_rqtype             (ch_req_rqtype),
        .ch_req_size               (ch_req_size),
        .ch_req_address            (ch_req_address),
        .ch_req_data               (ch_req_data),
        .ch_req_ack                (ch_req_ack),
        .transducer_l15_val        (transducer_l15_val),
        .transducer_l15_rqtype     (transducer_l15_rqtype),
        .transducer_l15_size       (transducer_l15_size),
        .transducer_l15_address    (transducer_l15_address),
        .transducer_l15_data       (transducer_l15_data),
        .transducer_l15_threadid   (transducer_l15_threadid),
        .l15_transducer_ack        (l15_transducer_ack),
        .l15_transducer_val        (l15_transducer_val),
        .l15_transducer_returntype (l15_transducer_returntype),
        .l15_transducer_data_0     (l15_transducer_data_0),
        .transducer_l15_req_ack    (transducer_l15_req_ack),
        .ch_resp_val               (ch_resp_val),
        .ch_resp_returntype        (ch_resp_returntype),
        .ch_resp_data              (ch_resp_data),
        .ch_resp_ack               (ch_resp_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [3:0]  mask;
        logic [39:0] addr;
        logic [63:0] data;
        logic [4:0]  rqtype;
    } req_exp_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [3:0]  rtype;
        logic [63:0] data;
    } resp_exp_t;

    req_exp_t  req_q[$];
    resp_exp_t resp_q[$];
    req_exp_t  mon_req;
    resp_exp_t mon_resp;
    logic [3:0] mon_prev_rv;
    int errors;
    int checks;

    function automatic logic [39:0] addr_of(input int c);
        return 40'h00_1000_0000 + 40'(c) * 40'h40;
    endfunction

    function automatic logic [63:0] data_of(input int c);
        return 64'hC0DE_0000_0000_0000 | 64'(c);
    endfunction

    function automatic logic [4:0] rqtype_of(input int c);
        return 5'(c + 1);
    endfunction

    function automatic req_exp_t req_exp(input int c);
        req_exp_t e;
        e.mask   = 4'(1 << c);
        e.addr   = addr_of(c);
        e.data   = data_of(c);
        e.rqtype = rqtype_of(c);
        return e;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: request acks and rising edges of ch_resp_val are matched
    // against the queues in order.
    initial begin
        mon_prev_rv = '0;
        forever begin
            @(negedge clk);
            if (ch_req_ack != '0) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req_ack: got %b expected none", ch_req_ack);
                end else begin
                    mon_req = req_q.pop_front();
                    chk("req_ack_grant", 64'(ch_req_ack), 64'(mon_req.mask));
                    chk("req_address", 64'(transducer_l15_address), 64'(mon_req.addr));
                    chk("req_data", transducer_l15_data, mon_req.data);
                    chk("req_rqtype", 64'(transducer_l15_rqtype), 64'(mon_req.rqtype));
                    chk("req_threadid", 64'(transducer_l15_threadid), 64'd0);
                end
            end
            if (ch_resp_val != '0 && mon_prev_rv == '0) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got %b expected none", ch_resp_val);
                end else begin
                    mon_resp = resp_q.pop_front();
                    chk("resp_val_route", 64'(ch_resp_val), 64'(mon_resp.mask));
                    chk("resp_rtype", 64'(ch_resp_returntype), 64'(mon_resp.rtype));
                    chk("resp_data", ch_resp_data, mon_resp.data);
                end
            end
            mon_prev_rv = ch_resp_val;
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] val_at_exit);
        rst_n                     = 1'b0;
        l15_transducer_ack        = 1'b0;
        l15_transducer_val        = 1'b0;
        l15_transducer_returntype = '0;
        l15_transducer_data_0     = '0;
        ch_resp_ack               = '0;
        ch_req_val                = val_at_exit;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic issue_ack(input int delay, input logic [3:0] clr_mask);
        int n;
        n = 0;
        while (!transducer_l15_val && n < 40) begin
            tick();
            n++;
        end
        if (!transducer_l15_val) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got val=0 expected val=1");
            return;
        end
        repeat (delay) tick();
        l15_transducer_ack = 1'b1;
        tick();
        l15_transducer_ack = 1'b0;
        ch_req_val = ch_req_val & ~clr_mask;
    endtask

    task automatic resp_routed(input logic [3:0] rtype, input logic [63:0] data, input int ch);
        resp_exp_t e;
        e.mask  = 4'(1 << ch);
        e.rtype = rtype;
        e.data  = data;
        resp_q.push_back(e);
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = rtype;
        l15_transducer_data_0     = data;
        tick();
        chk("routed_wait", 64'(transducer_l15_req_ack), 64'd0);
        ch_resp_ack = 4'(1 << ch);
        #1;
        chk("routed_req_ack", 64'(transducer_l15_req_ack), 64'd1);
        tick();
        ch_resp_ack        = '0;
        l15_transducer_val = 1'b0;
        tick();
    endtask

    task automatic resp_inv(input logic [63:0] data);
        resp_exp_t e;
        e.mask  = 4'b1111;
        e.rtype = RTYPE_INV;
        e.data  = data;
        resp_q.push_back(e);
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = RTYPE_INV;
        l15_transducer_data_0     = data;
        tick();
        for (int k = 0; k < 4; k++) begin
            ch_resp_ack = 4'(1 << k);
            #1;
            chk("inv_req_ack", 64'(transducer_l15_req_ack), (k == 3) ? 64'd1 : 64'd0);
            tick();
        end
        ch_resp_ack        = '0;
        l15_transducer_val = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_req_rqtype[c*5 +: 5]    = rqtype_of(c);
            ch_req_size[c*3 +: 3]      = 3'b011;
            ch_req_address[c*40 +: 40] = addr_of(c);
            ch_req_data[c*64 +: 64]    = data_of(c);
        end

        // Reset state
        do_reset(4'b0000);
        chk("rst_l15_val", 64'(transducer_l15_val), 64'd0);
        chk("rst_req_ack", 64'(ch_req_ack), 64'd0);
        chk("rst_resp_val", 64'(ch_resp_val), 64'd0);
        chk("rst_l15_req_ack", 64'(transducer_l15_req_ack), 64'd0);
        chk("rst_address", 64'(transducer_l15_address), 64'd0);
        chk("rst_fifo_count", 64'(dut.u_fifo.count), 64'd0);

        // Non-invalidation response with nothing outstanding is dropped
        l15_transducer_val        = 1'b1;
        l15_transducer_returntype = 4'h0;
        l15_transducer_data_0     = 64'h1234;
        #1;
        chk("drop_req_ack", 64'(transducer_l15_req_ack), 64'd1);
        chk("drop_resp_val", 64'(ch_resp_val), 64'd0);
        tick();
        l15_transducer_val = 1'b0;
        tick();

        // ch1 and ch3 valid at reset exit: ch1 first, then ch3
        req_q.push_back(req_exp(1));
        req_q.push_back(req_exp(3));
        do_reset(4'b1010);
        issue_ack(2, 4'b0010);
        issue_ack(2, 4'b1000);
        tick();
        chk("two_issued_count", 64'(dut.u_fifo.count), 64'd2);
        resp_routed(4'h0, 64'hDEAD_BEEF, 1);
        resp_routed(4'h0, 64'hDEAD_BEEF, 3);
        chk("two_drained_count", 64'(dut.u_fifo.count), 64'd0);

        // All channels valid: grant order 0..3, fifth blocked until a pop
        do_reset(4'b1111);
        for (int c = 0; c < 4; c++) req_q.push_back(req_exp(c));
        for (int c = 0; c < 4; c++) issue_ack(0, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("full_blocks_issue", 64'(transducer_l15_val), 64'd0);
        end
        chk("full_count", 64'(dut.u_fifo.count), 64'd4);
        for (int c = 0; c < 4; c++) begin
            req_q.push_back(req_exp(c));
            resp_routed(4'h0, 64'h5000 + 64'(c), c);
            issue_ack(0, 4'b0000);
        end
        ch_req_val = '0;
        for (int c = 0; c < 4; c++) resp_routed(4'h0, 64'h6000 + 64'(c), c);
        chk("rr_drained_count", 64'(dut.u_fifo.count), 64'd0);

        // ch2 then ch0; invalidation broadcast leaves the order intact
        do_reset(4'b0100);
        req_q.push_back(req_exp(2));
        issue_ack(1, 4'b0100);
        ch_req_val = 4'b0001;
        req_q.push_back(req_exp(0));
        issue_ack(1, 4'b0001);
        resp_inv(64'hFFFF_0000_AAAA_5555);
        chk("inv_count_kept", 64'(dut.u_fifo.count), 64'd2);
        resp_routed(4'h0, 64'hDEAD_BEEF, 2);
        resp_routed(4'h0, 64'hDEAD_BEEF, 0);

        // Reset during ISSUE: no ack pulse, FSM idle, FIFO cleared
        do_reset(4'b0001);
        req_q.push_back(req_exp(0));
        issue_ack(0, 4'b0001);
        ch_req_val = 4'b0010;
        for (int n = 0; n < 20 && !transducer_l15_val; n++) tick();
        chk("pre_rst_issue", 64'(transducer_l15_val), 64'd1);
        chk("pre_rst_count", 64'(dut.u_fifo.count), 64'd1);
        rst_n              = 1'b0;
        l15_transducer_ack = 1'b1;
        #1;
        chk("rst_mid_no_ack", 64'(ch_req_ack), 64'd0);
        tick();
        rst_n              = 1'b1;
        l15_transducer_ack = 1'b0;
        ch_req_val         = '0;
        chk("rst_mid_state", 64'(dut.state), 64'd0);
        chk("rst_mid_l15_val", 64'(transducer_l15_val), 64'd0);
        chk("rst_mid_count", 64'(dut.u_fifo.count), 64'd0);

        repeat (3) tick();
        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/l15_ch_arb.md
L15_CH_ARB -- requirements
Module: l15_ch_arb

Interface
REQ-001 Parameter NUM_CH, default 4, number of transducer channels sharing one L1.5 port (2..8).
REQ-002 Parameter ORD_DEPTH, default 4, order-FIFO depth and maximum outstanding requests (power of 2).
REQ-003 clk  input  1  sole clock.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 ch_req_val  input  NUM_CH  per-channel request valid.
REQ-006 ch_req_rqtype / ch_req_size / ch_req_address / ch_req_data  input  NUM_CH*5 / NUM_CH*3 / NUM_CH*40 / NUM_CH*64  flattened per-channel request fields.
REQ-007 ch_req_ack  output  NUM_CH  one-hot, one-cycle pulse: request accepted by L1.5.
REQ-008 transducer_l15_val / _rqtype / _size / _address / _data / _threadid  output  1/5/3/40/64/1  request to L1.5.
REQ-009 l15_transducer_ack  input  1  L1.5 request accept.
REQ-010 l15_transducer_val / _returntype / _data_0  input  1/4/64  L1.5 response.
REQ-011 transducer_l15_req_ack  output  1  response consumed.
REQ-012 ch_resp_val  output  NUM_CH  per-channel response valid; ch_resp_returntype 4 bits and ch_resp_data 64 bits, shared by all channels.
REQ-013 ch_resp_ack  input  NUM_CH  per-channel response consume.

Function
REQ-014 Request FSM states: IDLE, ISSUE; IDLE->ISSUE when any ch_req_val is set and the order FIFO is not full; ISSUE->IDLE on l15_transducer_ack.
REQ-015 In IDLE, grant is round-robin starting at the channel after the last granted one; the grant is latched and the request fields are registered.
REQ-016 In ISSUE, transducer_l15_val is 1 and the registered fields stay stable until ack; transducer_l15_threadid is 0.
REQ-017 On l15_transducer_ack, the block pulses ch_req_ack[grant] in the same cycle and pushes the grant index into the order FIFO.
REQ-018 Only the grant pointer advances on ack; an un-acked request is never re-arbitrated.
REQ-019 L1.5 returns non-invalidation responses in issue order; each such response is routed to the channel at the FIFO head.
REQ-020 A response with returntype 4'b0011 (invalidation) is broadcast: all ch_resp_val bits are set, the FIFO is not popped, and it completes when every channel has acked.
REQ-021 A routed response completes on ch_resp_ack of the target channel; it then pulses transducer_l15_req_ack for one cycle and pops the FIFO.
REQ-022 A push and a pop in the same cycle leave the count unchanged; a push to a full FIFO is impossible because IDLE blocks the grant.
REQ-023 A non-invalidation response with the FIFO empty is dropped with an immediate req_ack.
REQ-024 The round-robin pointer wraps from NUM_CH-1 to 0.

Reset
REQ-025 While rst_n=0 at a clk edge: FSM=IDLE, RR pointer=NUM_CH-1, FIFO count=0, all valids/acks=0, registered request fields=0.
REQ-026 Reset mid-ISSUE or mid-response abandons the transaction with no ack pulse.

Configuration
REQ-027 With macro L15_CH_ARB_RESP_BUF_EN: the response is captured into a one-entry register, transducer_l15_req_ack pulses on capture, and ch_resp_* are driven from the register, so L1.5 is freed one cycle after l15_transducer_val.
REQ-028 Without L15_CH_ARB_RESP_BUF_EN: ch_resp_* are combinational from the l15_transducer_* inputs, and req_ack waits for the channel ack(s) as in REQ-020 and REQ-021.

Structure
REQ-029 The shared package holds the FSM state enum, the returntype constant RTYPE_INV=4'b0011 and the field widths 5/3/40/64.
REQ-030 The order FIFO is a sub-module, l15_ch_arb_ord_fifo, parametrised by depth and index width.

Verification
REQ-031 Ch1 and ch3 both valid at reset exit, ack after 2 cycles each -> ch1 is issued first, then ch3; ch_req_ack=4'b0010 then 4'b1000.
REQ-032 All 4 channels continuously valid, 8 acks -> grant order 0,1,2,3,0,1,2,3.
REQ-033 Five issues with no responses, ORD_DEPTH=4 -> the fifth request stays un-granted until one response is consumed.
REQ-034 Responses returntype 0 with data 64'hDEAD_BEEF after issues from ch2 then ch0 -> ch_resp_val=4'b0100 first, then 4'b0001.
REQ-035 Invalidation response with ch0..ch3 acking on different cycles -> a single req_ack after the last ack, and the FIFO count is unchanged.
REQ-036 rst_n low for one cycle during ISSUE -> no ch_req_ack, FSM=IDLE and FIFO count=0 on the next cycle.
